// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//
// This block scans a 4x4 matrix keypad. It drives one column low at a time
// and samples the rows through a two-flop synchronizer. It also runs the
// settle handshake with the external debouncer. Each debounced press gives
// one key_valid pulse carrying the hex key_code. The block then waits for a
// debounced release before it starts scanning again.
//
// Ports:
//   clk                 - system clock, rising edge
//   reset               - synchronous, active-low reset
//   rows[3:0]           - raw keypad rows, asynchronous, active-low
//   debounce_done       - level from the debouncer: settle interval elapsed
//   cols[3:0]           - column drive, active-low one-cold
//   debounce_counter_en - asks the debouncer to count settling time
//   key_code[3:0]       - hex code of the last accepted key, held between accepts
//   key_valid           - one-cycle pulse when a key is accepted
//
// Parameter:
//   SCAN_DIV            - cycles each column is driven (minimum 4)
//
// Optional feature macro: KEYPAD_GHOST_REJECT_EN
//   When this macro is defined, the block rejects any sample that has more
//   than one row low. Such a sample cannot start a press. If it is present
//   when the press finishes settling, the press is swallowed with no pulse.

module keypad_scan_ctrl #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  input  logic       debounce_done,
  output logic [3:0] cols,
  output logic       debounce_counter_en,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam logic [1:0] ST_SCAN      = 2'd0;
  localparam logic [1:0] ST_DEB_PRESS = 2'd1;
  localparam logic [1:0] ST_HELD      = 2'd2;
  localparam logic [1:0] ST_DEB_REL   = 2'd3;

  localparam int            CW          = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SCNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] SCNT_SETTLE = CW'(2);

  logic [3:0]    rows_meta;
  logic [3:0]    rs;
  logic [1:0]    state, state_nxt;
  logic [1:0]    col, col_nxt;
  logic [1:0]    row, row_nxt;
  logic [CW-1:0] scnt, scnt_nxt;
  logic [3:0]    code_nxt;
  logic          valid_nxt;
  logic [1:0]    low_row;
  logic          key_seen;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Find the lowest-numbered row that is low. The loop runs from the top
  // down, so the lowest index is the one that sticks.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rs[i]) low_row = 2'(i);
    end
  end

`ifdef KEYPAD_GHOST_REJECT_EN
  logic multi_low;
  assign multi_low = ($countones(~rs) > 1);
  assign key_seen  = (rs != 4'hF) && !multi_low;
`else
  assign key_seen  = (rs != 4'hF);
`endif

  // Next-state logic. The column position and scan counter stay frozen while
  // a key is being handled, so a bounce can resume the same column directly.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    scnt_nxt  = scnt;
    code_nxt  = key_code;
    valid_nxt = 1'b0;
    case (state)
      ST_SCAN: begin
        // The first two cycles of each column are ignored. rs lags the
        // pads by two cycles, so those samples still belong to the previous column.
        if (scnt >= SCNT_SETTLE && key_seen) begin
          row_nxt   = low_row;
          state_nxt = ST_DEB_PRESS;
        end else if (scnt == SCNT_LAST) begin
          scnt_nxt = '0;
          col_nxt  = col + 2'd1;
        end else begin
          scnt_nxt = scnt + 1'b1;
        end
      end
      ST_DEB_PRESS: begin
        // If the row is released in the same cycle that done arrives, the
        // release wins and the press is treated as bounce.
        if (rs[row]) begin
          state_nxt = ST_SCAN;
          scnt_nxt  = '0;
        end else if (debounce_done) begin
          state_nxt = ST_HELD;
`ifdef KEYPAD_GHOST_REJECT_EN
          if (!multi_low) begin
            code_nxt  = key_map(row, col);
            valid_nxt = 1'b1;
          end
`else
          code_nxt  = key_map(row, col);
          valid_nxt = 1'b1;
`endif
        end
      end
      ST_HELD: begin
        if (rs[row]) state_nxt = ST_DEB_REL;
      end
      ST_DEB_REL: begin
        // If the row is pressed again in the same cycle that done arrives,
        // the re-press wins and the block goes back to HELD.
        if (!rs[row]) begin
          state_nxt = ST_HELD;
        end else if (debounce_done) begin
          state_nxt = ST_SCAN;
          col_nxt   = col + 2'd1;
          scnt_nxt  = '0;
        end
      end
      default: state_nxt = ST_SCAN;
    endcase
  end

  // All state and all outputs are registered. cols and the enable are
  // decoded from the next-state values, so they line up with the state
  // registers. Any exit from a settling state clears the enable for at
  // least one cycle, which restarts the debouncer from zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rows_meta           <= 4'hF;
      rs                  <= 4'hF;
      state               <= ST_SCAN;
      col                 <= 2'd0;
      row                 <= 2'd0;
      scnt                <= '0;
      cols                <= 4'b1110;
      debounce_counter_en <= 1'b0;
      key_code            <= 4'h0;
      key_valid           <= 1'b0;
    end else begin
      rows_meta           <= rows;
      rs                  <= rows_meta;
      state               <= state_nxt;
      col                 <= col_nxt;
      row                 <= row_nxt;
      scnt                <= scnt_nxt;
      cols                <= ~(4'b0001 << col_nxt);
      debounce_counter_en <= (state_nxt == ST_DEB_PRESS) || (state_nxt == ST_DEB_REL);
      key_code            <= code_nxt;
      key_valid           <= valid_nxt;
    end
  end

endmodule

// File: doc/keypad_scan_ctrl.md
# keypad_scan_ctrl

4x4 matrix-keypad scanner controller for the keypad/display path. It drives the keypad columns, samples the rows through a synchronizer and owns the handshake with the `debouncer` block: it raises `debounce_counter_en` while a press or release is settling and consumes `debounce_done`. Each debounced press produces exactly one `key_valid` pulse with a 4-bit hex `key_code`. The block then waits for a debounced release before it resumes scanning.

## Interface
- `SCAN_DIV`, default 4: cycles each column is driven; minimum 4.
- `clk` input 1: system clock, rising-edge.
- `reset` input 1: synchronous, active-low reset.
- `rows` input 4: raw keypad rows, asynchronous, active-low (pulled up); bit r = row r.
- `cols` output 4: column drive, active-low one-cold; bit c = column c.
- `debounce_counter_en` output 1: to debouncer; high = count settling time.
- `debounce_done` input 1: from debouncer; level, high once enable has been held for the full debounce interval; debouncer clears when enable is low.
- `key_code` output 4: hex value of the last accepted key; holds until the next accept.
- `key_valid` output 1: one-cycle pulse on accept.

## Operation
- Row synchronizer: two flops on `rows`; output `rs`; reset value 4'hF.
- Key map, (row, col) -> code:
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: E,0,F,D
- States: SCAN, DEB_PRESS, HELD, DEB_REL.
- SCAN:
  - `cols = ~(1<<col)`.
  - `scnt` counts 0..SCAN_DIV-1. At SCAN_DIV-1, `col` advances 3->0 wrap and `scnt` returns to 0.
  - Settle window: `rs` is ignored while `scnt` < 2.
  - If `scnt` >= 2 and `rs` != 4'hF: latch `col`, latch `row` = lowest-index low bit of `rs`, go to DEB_PRESS. `col`/`scnt` freeze.
- DEB_PRESS:
  - `debounce_counter_en` = 1.
  - `rs[row]` = 1 (bounce): go to SCAN, resume the same `col` with `scnt` = 0.
  - Else if `debounce_done` = 1: `key_code` <= map(row,col), `key_valid` <= 1, go to HELD.
  - If both happen in the same cycle, the release wins (bounce path).
- HELD:
  - `debounce_counter_en` = 0; columns stay frozen.
  - `rs[row]` = 1: go to DEB_REL.
  - Other keys pressed meanwhile are ignored.
- DEB_REL:
  - `debounce_counter_en` = 1.
  - `rs[row]` = 0 again: go to HELD.
  - Else `debounce_done` = 1: go to SCAN with `col` = latched col + 1 (wrap) and `scnt` = 0.
  - If both happen in the same cycle, the re-press wins.
- Every exit from DEB_PRESS/DEB_REL drops enable for at least 1 cycle, so the debouncer always restarts from zero.
- Reset mid-operation: the block returns to SCAN next cycle; any in-flight press is discarded with no `key_valid`.

## Timing
- Reset values:
  - `cols` = 4'b1110
  - `debounce_counter_en` = 0
  - `key_valid` = 0
  - `key_code` = 4'h0
  - state SCAN, `col` = 0, `scnt` = 0
- All outputs are registered.
- Row latency: pad change -> `rs` change takes 2 cycles.
- `debounce_counter_en` is high in the cycle after the SCAN->DEB_PRESS decision.
- `key_valid` is high in the cycle after `debounce_done` is sampled high in DEB_PRESS. `key_code` updates in that same cycle.
- `key_valid` is never high for two consecutive cycles. There is at most one pulse per press.
- Full scan period with no press: 4*SCAN_DIV cycles.

## Configuration
- `KEYPAD_GHOST_REJECT_EN`
  - Defined: in SCAN, if more than one bit of `rs` is low, no transition is taken (scan continues). In DEB_PRESS, if more than one bit of `rs` is low when `debounce_done` is sampled, the block goes to HELD without pulsing `key_valid`.
  - Undefined: the lowest-index low row is accepted and other rows are ignored.

## Test plan
All scenarios use SCAN_DIV=4.
- Reset low 2 cycles, `rows` = 4'hF: `cols` cycles 1110->1101->1011->0111, one step per 4 cycles; `debounce_counter_en` = 0; `key_valid` never set.
- Press (row1, col2) steady; bench asserts `debounce_done` 5 cycles after enable rises: exactly one `key_valid` pulse with `key_code` = 4'h6; `cols` frozen at 1011 until release.
- Press (row3, col1), then release 2 cycles into DEB_PRESS: enable drops and no `key_valid` occurs. Scan resumes at col1.
- Release bounce: in DEB_REL, row goes low again for 1 cycle: state returns to HELD, enable low 1 cycle then high again. The second `debounce_done` returns the block to SCAN with `cols` = 1011. No extra `key_valid`.
- Rows 0 and 2 low on col0:
  - Macro undefined: `key_code` = 4'h1.
  - Macro defined: no `key_valid`.
- `reset` asserted during HELD: next cycle `cols` = 1110, `debounce_counter_en` = 0, `key_code` = 0.
